sram_bank_sequencer: RTL and testbench
======================================

# sram_bank_sequencer

- Request front-end directly upstream of the 2-port SRAM register bank.
- Accepts read/write requests on a valid/ready handshake.
- Replays each request onto the bank's address, data and control pins on the exact Bennett-clock phase boundaries the bank expects, one transaction per Bennett cycle.
- Optionally captures the bank's read outputs at the end of the ramp-up half-cycle.

## Interface

Parameters:
- WIDTH, 10: number of Bennett phases; one full cycle = 2*WIDTH clk cycles; must be ≥ 10.
- ADDR_W, 5: register address width.
- DATA_W, 16: data width.

Ports:
- clk  in  1  system clock; same clock that drives the Bennett clock generator.
- reset  in  1  synchronous, active-high reset.
- cyc_start  in  1  high for one clk marks phase count 0 of a Bennett cycle (driven from instFlag).
- req_valid  in  1  request present.
- req_ready  out  1  request buffer empty.
- req_we  in  1  1 = write, 0 = read.
- req_addr_a  in  ADDR_W  port-A address (write target / read A).
- req_addr_b  in  ADDR_W  port-B address.
- req_data  in  DATA_W  write data.
- Addr_A, Addr_B  out  ADDR_W  to bank.
- in_data  out  DATA_W  to bank data input.
- RegWrtBar, WriteEn, ReadEn  out  1  bank control.
- outA, outB  in  DATA_W  bank read outputs.
- rd_a, rd_b  out  DATA_W  captured read data.
- rd_valid  out  1  one-clk pulse, capture valid.
- busy  out  1  transaction in flight.
- abort  out  1  one-clk pulse, transaction killed by resync.

## Operation

- Phase counter `ph`, range 0..2*WIDTH-1:
  - if cyc_start, next ph = 1; otherwise ph increments modulo 2*WIDTH.
  - Reset sets ph = 0.
- ph = k with k < WIDTH: clkpos[k] rose on that edge. Rising-edge phase k falls at ph = 2*WIDTH-1-k.
- One-entry request buffer:
  - handshake when req_valid && req_ready; req_ready = !pend.
  - Buffer is freed on launch.
- Launch: on the edge where ph goes 1→2, if pend = 1 and idle, the pending entry becomes active.
  - A handshake on that same edge is not launched; it waits for the next cycle.
- FSM: IDLE → ADDR (ph 2) → DATA (ph 4) → CTRL (ph 6) → EN (ph 8) → HOLD (ph 9) → RAMPDN (ph 10..2*WIDTH-1) → IDLE.
- Register updates, each taking effect on the edge where ph becomes the stated value:
  - Write:
    - ph 2: Addr_A/Addr_B loaded.
    - ph 4: in_data loaded.
    - ph 6: RegWrtBar = 1.
    - ph 8: WriteEn = 1.
    - ph 9: WriteEn = 0.
    - ph 2*WIDTH-7 (negedge of clkpos[6]): RegWrtBar = 0.
  - Read:
    - ph 2: addresses loaded.
    - ph 4: in_data loaded with req_data (don't-care to bank).
    - ph 6: ReadEn = 1.
    - ph 8: ReadEn = 0.
    - RegWrtBar and WriteEn stay 0.
- Addr_A, Addr_B and in_data hold their last values until the next launch overwrites them at ph 2.
- busy is high from launch through ph 2*WIDTH-1 inclusive.
- cyc_start while busy and ph ≠ 2*WIDTH-1 (resync):
  - next edge clears WriteEn, ReadEn, RegWrtBar;
  - active transaction is dropped and abort pulses;
  - FSM goes to IDLE;
  - pending buffer is kept.
- Reset: all outputs 0, pend = 0, FSM IDLE, req_ready = 1 from the first post-reset cycle.

## Timing

- Request-to-bank latency: a request accepted at ph 0 or 1 drives Addr_A/Addr_B 2 or 1 clks later (at ph 2).
  - Worst case: accepted at ph 2, waits 2*WIDTH clks.
- Throughput: one transaction per 2*WIDTH clks; back-to-back requests need no idle cycle.
  - The second request can be accepted from ph 2 of the first.
- Read capture: rd_a/rd_b register outA/outB on the edge where ph becomes WIDTH-1 (ph 9 at WIDTH = 10); rd_valid is high that same cycle only.
- All outputs are registered; no combinational path from request inputs to bank pins.
- req_ready drops the clk after handshake and rises the clk after launch.

## Configuration

- SRAM_SEQ_READBACK_EN defined: read-capture path compiled in (rd_a, rd_b, rd_valid as above).
- SRAM_SEQ_READBACK_EN undefined: capture registers omitted; rd_a/rd_b tied 0, rd_valid tied 0; outA/outB unused. Write path unchanged.

## Test plan

- Reset then cyc_start at clk 0, write req (addr_a 5'h02, addr_b 5'h1F, data 16'hAAAA) at ph 0 → ph 2 Addr_A = 02/Addr_B = 1F, ph 4 in_data = AAAA, ph 6 RegWrtBar = 1, WriteEn high exactly ph 8, RegWrtBar = 0 at ph 13; bank word 2 = AAAA.
- Following read req (addr_a 5'h02, addr_b 5'h01) → ReadEn high ph 6..7 only; with SRAM_SEQ_READBACK_EN, rd_valid pulse at ph 9 with rd_a = 16'hAAAA.
- Two requests presented back-to-back: second accepted at ph 2 of first, req_ready low until next ph 2; second launches at the next cycle's ph 2 with no gap.
- Request arriving exactly at the ph 1→2 edge → not launched this cycle; Addr_A changes only at the next cycle's ph 2.
- cyc_start asserted at ph 8 of a write → WriteEn and RegWrtBar 0 the next clk, abort pulses once, FSM IDLE, pending request launches at the new ph 2.
- reset asserted mid-write at ph 7 → next clk all outputs 0, req_ready = 1, busy = 0.

Source files
------------

// File: rtl/sram_bank_sequencer.sv
// Request front-end for the 2-port SRAM bank: replays each accepted request onto the bank pins on Bennett phase boundaries.
// Read-capture path (rd_a/rd_b/rd_valid) is compiled in only when SRAM_SEQ_READBACK_EN is defined.
//
// state  | meaning
// IDLE   | no transaction; pending entry launches on the ph 1->2 edge
// ADDR   | Addr_A/Addr_B driven (ph 2..3)
// DATA   | in_data driven (ph 4..5)
// CTRL   | RegWrtBar (write) or ReadEn (read) high (ph 6..7)
// EN     | WriteEn pulse for writes, ReadEn released (ph 8)
// HOLD   | enables released (ph 9)
// RAMPDN | ramp-down half; RegWrtBar drops at ph 2*WIDTH-7 (ph 10..2*WIDTH-1)
module sram_bank_sequencer #(
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cyc_start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] Addr_A,
    output logic [ADDR_W-1:0] Addr_B,
    output logic [DATA_W-1:0] in_data,
    output logic              RegWrtBar,
    output logic              WriteEn,
    output logic              ReadEn,
    input  logic [DATA_W-1:0] outA,
    input  logic [DATA_W-1:0] outB,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic              rd_valid,
    output logic              busy,
    output logic              abort
);
    localparam int NPH  = 2 * WIDTH;
    localparam int PH_W = $clog2(NPH);
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(NPH - 1);
    localparam logic [PH_W-1:0] PH_RWB_OFF = PH_W'(NPH - 7);
    localparam logic [PH_W-1:0] PH_CAPT    = PH_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, CTRL, EN, HOLD, RAMPDN} state_t;

    state_t            state;
    logic [PH_W-1:0]   ph;
    logic [PH_W-1:0]   ph_nxt;
    logic              pend;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_a;
    logic [ADDR_W-1:0] buf_b;
    logic [DATA_W-1:0] buf_data;
    logic              act_we;
    logic [DATA_W-1:0] act_data;
    logic              handshake;
    logic              launch;
    logic              resync;

    always_comb begin
        if (cyc_start)
            ph_nxt = PH_W'(1);
        else if (ph == PH_LAST)
            ph_nxt = '0;
        else
            ph_nxt = ph + PH_W'(1);
    end

    assign req_ready = ~pend;
    assign handshake = req_valid & ~pend;
    assign launch    = pend & (state == IDLE) & (ph_nxt == PH_W'(2));
    assign resync    = cyc_start & busy & (ph != PH_LAST);

    always_ff @(posedge clk) begin
        if (reset)
            ph <= '0;
        else
            ph <= ph_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= 1'b0;
            buf_we    <= 1'b0;
            buf_a     <= '0;
            buf_b     <= '0;
            buf_data  <= '0;
            act_we    <= 1'b0;
            act_data  <= '0;
            Addr_A    <= '0;
            Addr_B    <= '0;
            in_data   <= '0;
            RegWrtBar <= 1'b0;
            WriteEn   <= 1'b0;
            ReadEn    <= 1'b0;
            busy      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;
            if (handshake) begin
                pend     <= 1'b1;
                buf_we   <= req_we;
                buf_a    <= req_addr_a;
                buf_b    <= req_addr_b;
                buf_data <= req_data;
            end
            // A resync kills the active transaction but leaves the pending entry alone.
            if (resync) begin
                state     <= IDLE;
                busy      <= 1'b0;
                RegWrtBar <= 1'b0;
                WriteEn   <= 1'b0;
                ReadEn    <= 1'b0;
                abort     <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (launch) begin
                        state    <= ADDR;
                        busy     <= 1'b1;
                        pend     <= 1'b0;
                        Addr_A   <= buf_a;
                        Addr_B   <= buf_b;
                        act_we   <= buf_we;
                        act_data <= buf_data;
                    end
                    ADDR: if (ph_nxt == PH_W'(4)) begin
                        state   <= DATA;
                        in_data <= act_data;
                    end
                    DATA: if (ph_nxt == PH_W'(6)) begin
                        state <= CTRL;
                        if (act_we)
                            RegWrtBar <= 1'b1;
                        else
                            ReadEn <= 1'b1;
                    end
                    CTRL: if (ph_nxt == PH_W'(8)) begin
                        state  <= EN;
                        ReadEn <= 1'b0;
                        if (act_we)
                            WriteEn <= 1'b1;
                    end
                    EN: if (ph_nxt == PH_W'(9)) begin
                        state   <= HOLD;
                        WriteEn <= 1'b0;
                    end
                    HOLD: if (ph_nxt == PH_W'(10))
                        state <= RAMPDN;
                    RAMPDN: begin
                        if (ph_nxt == PH_RWB_OFF)
                            RegWrtBar <= 1'b0;
                        if (ph == PH_LAST) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            RegWrtBar <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SRAM_SEQ_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_a     <= '0;
            rd_b     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (busy && !resync && !act_we && ph_nxt == PH_CAPT) begin
                rd_a     <= outA;
                rd_b     <= outB;
                rd_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{outA, outB};
    assign rd_a      = '0;
    assign rd_b      = '0;
    assign rd_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Self-checking bench for sram_bank_sequencer: directed scenarios plus randomized traffic against a phase-window reference model.
// Expectations for the capture path follow SRAM_SEQ_READBACK_EN.
module tb_sram_bank_sequencer;
    localparam int WIDTH  = 10;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int NPH    = 2 * WIDTH;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [DATA_W-1:0] d;
    } txn_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cyc_start = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr_a = '0;
    logic [ADDR_W-1:0] req_addr_b = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic [ADDR_W-1:0] Addr_A, Addr_B;
    logic [DATA_W-1:0] in_data;
    logic              RegWrtBar, WriteEn, ReadEn;
    logic [DATA_W-1:0] outA, outB;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              rd_valid, busy, abort;

    int n_tests = 0;
    int n_fail  = 0;

    sram_bank_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .cyc_start(cyc_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_data(req_data),
        .Addr_A(Addr_A), .Addr_B(Addr_B), .in_data(in_data),
        .RegWrtBar(RegWrtBar), .WriteEn(WriteEn), .ReadEn(ReadEn),
        .outA(outA), .outB(outB), .rd_a(rd_a), .rd_b(rd_b),
        .rd_valid(rd_valid), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    // Behavioural bank: writes on WriteEn, combinational read ports.
    logic [DATA_W-1:0] bank_mem [32];
    logic [DATA_W-1:0] ref_mem  [32];
    assign outA = bank_mem[Addr_A];
    assign outB = bank_mem[Addr_B];
    always @(posedge clk) if (WriteEn) bank_mem[Addr_A] = in_data;

    // Reference model: one pending slot, one active transaction, pins as windows of the phase count.
    int                m_ph = 0;
    logic              m_pend = 1'b0;
    logic              m_act = 1'b0;
    txn_t              m_cur = '0;
    txn_t              m_pbuf = '0;
    logic              mh_hs, mh_launch;
    logic [ADDR_W-1:0] e_addr_a = '0, e_addr_b = '0;
    logic [DATA_W-1:0] e_data = '0, e_rd_a = '0, e_rd_b = '0;
    logic              e_rdv = 1'b0, e_abort = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_pend = 1'b0; m_act = 1'b0;
            e_addr_a = '0; e_addr_b = '0; e_data = '0;
            e_rd_a = '0; e_rd_b = '0; e_rdv = 1'b0; e_abort = 1'b0;
        end else begin
            mh_hs     = req_valid && !m_pend;
            mh_launch = !m_act && m_pend && m_ph == 1 && !cyc_start;
            if (m_act && m_cur.we && m_ph == 8) ref_mem[m_cur.a] = m_cur.d;
            e_abort = cyc_start && m_act && m_ph != NPH - 1;
            if (m_act && (e_abort || m_ph == NPH - 1)) m_act = 1'b0;
            if (mh_launch) begin
                m_act = 1'b1; m_cur = m_pbuf; m_pend = 1'b0;
                e_addr_a = m_pbuf.a; e_addr_b = m_pbuf.b;
            end
            if (mh_hs) begin
                m_pend = 1'b1;
                m_pbuf = {req_we, req_addr_a, req_addr_b, req_data};
            end
            m_ph = cyc_start ? 1 : (m_ph + 1) % NPH;
            if (m_act && m_ph == 4) e_data = m_cur.d;
            e_rdv = 1'b0;
`ifdef SRAM_SEQ_READBACK_EN
            if (m_act && !m_cur.we && m_ph == WIDTH - 1) begin
                e_rdv = 1'b1; e_rd_a = ref_mem[m_cur.a]; e_rd_b = ref_mem[m_cur.b];
            end
`endif
        end
    end

    logic [ADDR_W-1:0] prev_a;

    task automatic step(input bit force_cs);
        bit rdy;
        cyc_start = force_cs || (m_ph == 0);
        rdy = req_ready;
        @(posedge clk); #1;
        if (req_valid && rdy) req_valid = 1'b0;
        cyc_start = 1'b0;
    endtask

    task automatic present(input txn_t t);
        req_we = t.we; req_addr_a = t.a; req_addr_b = t.b; req_data = t.d;
        req_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step(0);
        n_tests++;
        if ({Addr_A, Addr_B, in_data, RegWrtBar, WriteEn, ReadEn, rd_a, rd_b, rd_valid, busy, abort} !== '0) begin
            n_fail++; $display("FAIL reset_outputs busy=%b RegWrtBar=%b WriteEn=%b Addr_A=%h in_data=%h required all 0", busy, RegWrtBar, WriteEn, Addr_A, in_data);
        end
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready req_ready=%b required 1", req_ready); end
        reset = 1'b0;
    endtask

    task automatic test_write();
        int p;
        present({1'b1, 5'h02, 5'h1F, 16'hAAAA});
        for (int k = 0; k < NPH; k++) begin
            step(0);
            p = m_ph;
            n_tests++;
            if (WriteEn !== (p == 8)) begin n_fail++; $display("FAIL wr_writeen ph=%0d WriteEn=%b required %b", p, WriteEn, p == 8); end
            n_tests++;
            if (RegWrtBar !== (p >= 6 && p <= NPH - 8)) begin
                n_fail++; $display("FAIL wr_regwrtbar ph=%0d RegWrtBar=%b required %b", p, RegWrtBar, p >= 6 && p <= NPH - 8);
            end
            if (p == 2) begin
                n_tests++;
                if ({Addr_A, Addr_B} !== {5'h02, 5'h1F}) begin n_fail++; $display("FAIL wr_addr Addr_A=%h Addr_B=%h required 02/1f", Addr_A, Addr_B); end
            end
            if (p == 4) begin
                n_tests++;
                if (in_data !== 16'hAAAA) begin n_fail++; $display("FAIL wr_data in_data=%h required aaaa", in_data); end
            end
        end
        n_tests++;
        if (bank_mem[2] !== 16'hAAAA) begin n_fail++; $display("FAIL wr_bank word2=%h required aaaa", bank_mem[2]); end
    endtask

    task automatic test_read();
        int p;
        present({1'b0, 5'h02, 5'h01, 16'($urandom)});
        for (int k = 0; k < NPH; k++) begin
            step(0);
            p = m_ph;
            n_tests++;
            if (ReadEn !== (p == 6 || p == 7)) begin n_fail++; $display("FAIL rd_readen ph=%0d ReadEn=%b required %b", p, ReadEn, p == 6 || p == 7); end
            n_tests++;
            if ({RegWrtBar, WriteEn} !== 2'b00) begin n_fail++; $display("FAIL rd_wctl ph=%0d RegWrtBar=%b WriteEn=%b required 0", p, RegWrtBar, WriteEn); end
`ifdef SRAM_SEQ_READBACK_EN
            n_tests++;
            if (rd_valid !== (p == WIDTH - 1)) begin n_fail++; $display("FAIL rd_valid ph=%0d rd_valid=%b required %b", p, rd_valid, p == WIDTH - 1); end
            if (p == WIDTH - 1) begin
                n_tests++;
                if ({rd_a, rd_b} !== {16'hAAAA, ref_mem[1]}) begin
                    n_fail++; $display("FAIL rd_capture rd_a=%h rd_b=%h required aaaa/%h", rd_a, rd_b, ref_mem[1]);
                end
            end
`else
            n_tests++;
            if ({rd_valid, rd_a, rd_b} !== '0) begin n_fail++; $display("FAIL rd_tied ph=%0d rd_valid=%b rd_a=%h rd_b=%h required 0", p, rd_valid, rd_a, rd_b); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        txn_t t1, t2;
        t1 = {1'b1, 5'($urandom), 5'($urandom), 16'($urandom)};
        t2 = {1'b0, t1.a ^ 5'h01, 5'($urandom), 16'($urandom)};
        present(t1);
        step(0);
        present(t2);
        for (int k = 0; k <= NPH; k++) begin
            step(0);
            if (k >= 1 && k <= NPH - 1) begin
                n_tests++;
                if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low ph=%0d req_ready=%b required 0", m_ph, req_ready); end
            end
            if (k == 0 || k == NPH) begin
                n_tests++;
                if ({req_ready, busy, Addr_A} !== {2'b11, (k == 0) ? t1.a : t2.a}) begin
                    n_fail++; $display("FAIL b2b_launch k=%0d ready=%b busy=%b Addr_A=%h required 1/1/%h", k, req_ready, busy, Addr_A, (k == 0) ? t1.a : t2.a);
                end
            end
        end
        repeat (NPH - 2) step(0);
        prev_a = t2.a;
    endtask

    task automatic test_late_request();
        txn_t t;
        t = {1'b1, prev_a ^ 5'h0A, 5'($urandom), 16'($urandom)};
        step(0);
        present(t);
        step(0);
        n_tests++;
        if ({busy, req_ready, Addr_A} !== {2'b00, prev_a}) begin
            n_fail++; $display("FAIL late_no_launch busy=%b ready=%b Addr_A=%h required 0/0/%h", busy, req_ready, Addr_A, prev_a);
        end
        repeat (NPH - 1) step(0);
        n_tests++;
        if (Addr_A !== prev_a) begin n_fail++; $display("FAIL late_hold ph=%0d Addr_A=%h required %h", m_ph, Addr_A, prev_a); end
        step(0);
        n_tests++;
        if ({busy, Addr_A} !== {1'b1, t.a}) begin n_fail++; $display("FAIL late_launch busy=%b Addr_A=%h required 1/%h", busy, Addr_A, t.a); end
        repeat (NPH - 2) step(0);
    endtask

    task automatic test_resync();
        txn_t w, r;
        w = {1'b1, 5'($urandom), 5'($urandom), 16'($urandom)};
        r = {1'b0, w.a ^ 5'h11, 5'($urandom), 16'($urandom)};
        present(w);
        step(0);
        present(r);
        repeat (7) step(0);
        n_tests++;
        if ({WriteEn, RegWrtBar} !== 2'b11) begin n_fail++; $display("FAIL resync_pre WriteEn=%b RegWrtBar=%b required 1/1", WriteEn, RegWrtBar); end
        step(1);
        n_tests++;
        if ({WriteEn, RegWrtBar, ReadEn, abort, busy, req_ready} !== 6'b000100) begin
            n_fail++; $display("FAIL resync_kill WriteEn=%b RegWrtBar=%b ReadEn=%b abort=%b busy=%b ready=%b required 0/0/0/1/0/0",
                               WriteEn, RegWrtBar, ReadEn, abort, busy, req_ready);
        end
        step(0);
        n_tests++;
        if ({abort, busy, Addr_A, Addr_B} !== {2'b01, r.a, r.b}) begin
            n_fail++; $display("FAIL resync_relaunch abort=%b busy=%b Addr=%h/%h required 0/1/%h/%h", abort, busy, Addr_A, Addr_B, r.a, r.b);
        end
        repeat (NPH - 2) step(0);
    endtask

    task automatic test_reset_mid_write();
        present({1'b1, 5'($urandom), 5'($urandom), 16'($urandom)});
        repeat (7) step(0);
        n_tests++;
        if (RegWrtBar !== 1'b1) begin n_fail++; $display("FAIL midrst_pre RegWrtBar=%b required 1", RegWrtBar); end
        reset = 1'b1;
        step(0);
        n_tests++;
        if ({req_ready, Addr_A, Addr_B, in_data, RegWrtBar, WriteEn, ReadEn, rd_a, rd_b, rd_valid, busy, abort} !== {1'b1, 64'd0}) begin
            n_fail++; $display("FAIL midrst_outputs ready=%b busy=%b RegWrtBar=%b Addr_A=%h in_data=%h required 1 then all 0", req_ready, busy, RegWrtBar, Addr_A, in_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [64:0] act_v, exp_v;
        logic        rwb, wen, ren;
        for (int k = 0; k < 1500; k++) begin
            if (!req_valid && $urandom_range(0, 2) == 0)
                present({1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom)});
            step($urandom_range(0, 49) == 0);
            rwb = m_act && m_cur.we && m_ph >= 6 && m_ph <= NPH - 8;
            wen = m_act && m_cur.we && m_ph == 8;
            ren = m_act && !m_cur.we && (m_ph == 6 || m_ph == 7);
            act_v = {req_ready, Addr_A, Addr_B, in_data, RegWrtBar, WriteEn, ReadEn, rd_a, rd_b, rd_valid, busy, abort};
            exp_v = {!m_pend, e_addr_a, e_addr_b, e_data, rwb, wen, ren, e_rd_a, e_rd_b, e_rdv, m_act, e_abort};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL random cycle=%0d ph=%0d outputs=%h required %h", k, m_ph, act_v, exp_v);
            end
        end
        req_valid = 1'b0;
        repeat (2 * NPH) step(0);
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (bank_mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL random_bank word=%0d value=%h required %h", i, bank_mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            bank_mem[i] = 16'($urandom);
            ref_mem[i]  = bank_mem[i];
        end
        prev_a = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_late_request();
        test_resync();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
